// File: rtl/hazard_ctrl_mc_if.sv
// Hazard-controller bundle: EX/ID register-file hazard info, EX redirect, MEM handshake,
// and the stall/flush/counter outputs back to the pipeline.
interface hazard_ctrl_mc_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              rf_we_ex;
    logic [1:0]        rf_wd_sel_ex;
    logic [REG_AW-1:0] rf_wa_ex;
    logic [REG_AW-1:0] rf_ra0_id;
    logic [REG_AW-1:0] rf_ra1_id;
    logic              rf_re0_id;
    logic              rf_re1_id;
    logic [1:0]        npc_sel;
    logic              mem_req_mem;
    logic              mem_ready_mem;
    logic              stall_pc;
    logic              stall_if2id;
    logic              stall_id2ex;
    logic              stall_ex2mem;
    logic              flush_if2id;
    logic              flush_id2ex;
    logic              flush_mem2wb;
    logic [CNT_W-1:0]  cnt_stall;
    logic [CNT_W-1:0]  cnt_flush;

    modport master (
        output rf_we_ex, rf_wd_sel_ex, rf_wa_ex, rf_ra0_id, rf_ra1_id, rf_re0_id, rf_re1_id,
               npc_sel, mem_req_mem, mem_ready_mem,
        input  stall_pc, stall_if2id, stall_id2ex, stall_ex2mem,
               flush_if2id, flush_id2ex, flush_mem2wb, cnt_stall, cnt_flush
    );

    modport slave (
        input  rf_we_ex, rf_wd_sel_ex, rf_wa_ex, rf_ra0_id, rf_ra1_id, rf_re0_id, rf_re1_id,
               npc_sel, mem_req_mem, mem_ready_mem,
        output stall_pc, stall_if2id, stall_id2ex, stall_ex2mem,
               flush_if2id, flush_id2ex, flush_mem2wb, cnt_stall, cnt_flush
    );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// 5-stage RV32 hazard/segment controller: multi-cycle load-use stall, data-memory wait freeze,
// redirect flush (deferred while frozen) and saturating stall/flush counters.
module hazard_ctrl_mc #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rstn,
    hazard_ctrl_mc_if.slave  hz
);
    typedef enum logic [1:0] {RUN, LU_WAIT, MEM_WAIT} state_t;

    localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] cnt_stall_q, cnt_flush_q;

    logic lu_hit, mem_busy, redirect, lu_resume, flush_take;
    logic st_pc, st_if2id, st_id2ex, st_ex2mem, fl_if2id, fl_id2ex, fl_mem2wb;

    assign lu_hit = hz.rf_we_ex && (hz.rf_wd_sel_ex == 2'b01) && (hz.rf_wa_ex != '0) &&
                    ((hz.rf_re0_id && (hz.rf_wa_ex == hz.rf_ra0_id)) ||
                     (hz.rf_re1_id && (hz.rf_wa_ex == hz.rf_ra1_id)));
    assign mem_busy  = hz.mem_req_mem && !hz.mem_ready_mem;
    assign redirect  = (hz.npc_sel == 2'b01) || (hz.npc_sel == 2'b10);
    // lu_cnt is non-zero only while a load-use bubble sequence is outstanding
    assign lu_resume = (state_q == LU_WAIT) || ((state_q == MEM_WAIT) && (lu_cnt_q != '0));

    always_comb begin
        state_d    = state_q;
        lu_cnt_d   = lu_cnt_q;
        flush_take = 1'b0;
        st_pc      = 1'b0;
        st_if2id   = 1'b0;
        st_id2ex   = 1'b0;
        st_ex2mem  = 1'b0;
        fl_if2id   = 1'b0;
        fl_id2ex   = 1'b0;
        fl_mem2wb  = 1'b0;
        if (!rstn) begin
            state_d  = RUN;
            lu_cnt_d = '0;
        end else if (mem_busy) begin
            st_pc     = 1'b1;
            st_if2id  = 1'b1;
            st_id2ex  = 1'b1;
            st_ex2mem = 1'b1;
            fl_mem2wb = 1'b1;
            state_d   = MEM_WAIT;
        end else if (lu_resume) begin
            st_pc    = 1'b1;
            st_if2id = 1'b1;
            fl_id2ex = 1'b1;
            if (lu_cnt_q == 3'd1) begin
                state_d  = RUN;
                lu_cnt_d = '0;
            end else begin
                state_d  = LU_WAIT;
                lu_cnt_d = lu_cnt_q - 3'd1;
            end
        end else if (lu_hit) begin
            st_pc    = 1'b1;
            st_if2id = 1'b1;
            fl_id2ex = 1'b1;
            if (LOAD_LAT > 1) begin
                state_d  = LU_WAIT;
                lu_cnt_d = LU_INIT;
            end else begin
                state_d  = RUN;
            end
        end else begin
            state_d = RUN;
            if (redirect) begin
                fl_if2id   = 1'b1;
                fl_id2ex   = 1'b1;
                flush_take = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= RUN;
            lu_cnt_q    <= '0;
            cnt_stall_q <= '0;
            cnt_flush_q <= '0;
        end else begin
            state_q     <= state_d;
            lu_cnt_q    <= lu_cnt_d;
            cnt_stall_q <= sat_inc(cnt_stall_q, st_pc);
            cnt_flush_q <= sat_inc(cnt_flush_q, flush_take);
        end
    end

    assign hz.stall_pc     = st_pc;
    assign hz.stall_if2id  = st_if2id;
    assign hz.stall_id2ex  = st_id2ex;
    assign hz.stall_ex2mem = st_ex2mem;
    assign hz.flush_if2id  = fl_if2id;
    assign hz.flush_id2ex  = fl_id2ex;
    assign hz.flush_mem2wb = fl_mem2wb;
    assign hz.cnt_stall    = cnt_stall_q;
    assign hz.cnt_flush    = cnt_flush_q;
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench: two controllers (LOAD_LAT=3/32-bit counters, LOAD_LAT=1/2-bit counters)
// share one directed stimulus stream; a negedge monitor pops and checks expected outputs.
module tb_hazard_ctrl_mc;
    localparam logic [6:0] O_NO  = 7'b0000000;
    localparam logic [6:0] O_LU  = 7'b1100010;
    localparam logic [6:0] O_MEM = 7'b1111001;
    localparam logic [6:0] O_RD  = 7'b0000110;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic we = 1'b0, re0 = 1'b0, re1 = 1'b0, req = 1'b0, rdy = 1'b0;
    logic [1:0] sel = 2'b00, npc = 2'b00;
    logic [4:0] wa = '0, ra0 = '0, ra1 = '0;
    logic n_we, n_re0, n_re1;
    logic [1:0] n_sel;
    logic [4:0] n_wa, n_ra0, n_ra1;

    int total = 0;
    int bad = 0;

    typedef struct {
        string      nm;
        logic [6:0] e3;
        logic [6:0] e1;
        int         cs3, cf3, cs1, cf1;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    hazard_ctrl_mc_if #(.REG_AW(5), .CNT_W(32)) hz3 ();
    hazard_ctrl_mc_if #(.REG_AW(5), .CNT_W(2))  hz1 ();

    assign hz3.rf_we_ex = we;   assign hz1.rf_we_ex = we;
    assign hz3.rf_wd_sel_ex = sel; assign hz1.rf_wd_sel_ex = sel;
    assign hz3.rf_wa_ex = wa;   assign hz1.rf_wa_ex = wa;
    assign hz3.rf_ra0_id = ra0; assign hz1.rf_ra0_id = ra0;
    assign hz3.rf_ra1_id = ra1; assign hz1.rf_ra1_id = ra1;
    assign hz3.rf_re0_id = re0; assign hz1.rf_re0_id = re0;
    assign hz3.rf_re1_id = re1; assign hz1.rf_re1_id = re1;
    assign hz3.npc_sel = npc;   assign hz1.npc_sel = npc;
    assign hz3.mem_req_mem = req;   assign hz1.mem_req_mem = req;
    assign hz3.mem_ready_mem = rdy; assign hz1.mem_ready_mem = rdy;

    hazard_ctrl_mc #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(32)) dut3 (.clk(clk), .rstn(rstn), .hz(hz3.slave));
    hazard_ctrl_mc #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(2))  dut1 (.clk(clk), .rstn(rstn), .hz(hz1.slave));

    wire [6:0] o3 = {hz3.stall_pc, hz3.stall_if2id, hz3.stall_id2ex, hz3.stall_ex2mem,
                     hz3.flush_if2id, hz3.flush_id2ex, hz3.flush_mem2wb};
    wire [6:0] o1 = {hz1.stall_pc, hz1.stall_if2id, hz1.stall_id2ex, hz1.stall_ex2mem,
                     hz1.flush_if2id, hz1.flush_id2ex, hz1.flush_mem2wb};

    function automatic int sat2(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.nm, " out3"}, {25'd0, o3}, {25'd0, e.e3});
            chk({e.nm, " out1"}, {25'd0, o1}, {25'd0, e.e1});
            if (e.cs3 >= 0) begin
                chk({e.nm, " cnt_stall3"}, hz3.cnt_stall, e.cs3);
                chk({e.nm, " cnt_flush3"}, hz3.cnt_flush, e.cf3);
                chk({e.nm, " cnt_stall1"}, {30'd0, hz1.cnt_stall}, sat2(e.cs1));
                chk({e.nm, " cnt_flush1"}, {30'd0, hz1.cnt_flush}, sat2(e.cf1));
            end
        end
    end

    task automatic regs(input logic w, input logic [1:0] s, input logic [4:0] a,
                        input logic [4:0] r0, input logic e0, input logic [4:0] r1, input logic e1);
        n_we = w; n_sel = s; n_wa = a; n_ra0 = r0; n_re0 = e0; n_ra1 = r1; n_re1 = e1;
    endtask

    task automatic hzd(); regs(1'b1, 2'b01, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1); endtask
    task automatic nop(); regs(1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); endtask

    task automatic step(input string nm, input logic r, input logic [1:0] np, input logic rq,
                        input logic rd, input logic [6:0] e3, input logic [6:0] e1,
                        input int cs3, input int cf3, input int cs1, input int cf1);
        exp_t e;
        @(posedge clk);
        #1;
        rstn = r; npc = np; req = rq; rdy = rd;
        we = n_we; sel = n_sel; wa = n_wa; ra0 = n_ra0; re0 = n_re0; ra1 = n_ra1; re1 = n_re1;
        e.nm = nm; e.e3 = e3; e.e1 = e1; e.cs3 = cs3; e.cf3 = cf3; e.cs1 = cs1; e.cf1 = cf1;
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hzd(); step("rst0", 0, 2'b00, 0, 0, O_NO, O_NO, -1, -1, -1, -1);
        hzd(); step("rst1", 0, 2'b00, 0, 0, O_NO, O_NO, 0, 0, 0, 0);
        nop(); step("idle", 1, 2'b00, 0, 0, O_NO, O_NO, 0, 0, 0, 0);
        hzd(); step("lu_a", 1, 2'b00, 0, 0, O_LU, O_LU, 0, 0, 0, 0);
        nop(); step("lu_b", 1, 2'b00, 0, 0, O_LU, O_NO, 1, 0, 1, 0);
        nop(); step("lu_c", 1, 2'b00, 0, 0, O_LU, O_NO, 2, 0, 1, 0);
        nop(); step("lu_end", 1, 2'b00, 0, 0, O_NO, O_NO, 3, 0, 1, 0);
        regs(1, 2'b01, 5'd0, 5'd0, 1, 5'd0, 1);
        step("x0", 1, 2'b00, 0, 0, O_NO, O_NO, 3, 0, 1, 0);
        regs(1, 2'b01, 5'd5, 5'd5, 0, 5'd5, 0);
        step("re_off", 1, 2'b00, 0, 0, O_NO, O_NO, 3, 0, 1, 0);
        regs(1, 2'b00, 5'd5, 5'd5, 1, 5'd0, 0);
        step("not_load", 1, 2'b00, 0, 0, O_NO, O_NO, 3, 0, 1, 0);
        regs(0, 2'b01, 5'd5, 5'd5, 1, 5'd0, 0);
        step("no_we", 1, 2'b00, 0, 0, O_NO, O_NO, 3, 0, 1, 0);
        regs(1, 2'b01, 5'd7, 5'd7, 1, 5'd0, 0);
        step("lu_ra0", 1, 2'b00, 0, 0, O_LU, O_LU, 3, 0, 1, 0);
        nop(); step("lu_rd", 1, 2'b01, 0, 0, O_LU, O_RD, 4, 0, 2, 0);
        nop(); step("lu_tail", 1, 2'b00, 0, 0, O_LU, O_NO, 5, 0, 2, 1);
        nop(); step("redir", 1, 2'b01, 0, 0, O_RD, O_RD, 6, 0, 2, 1);
        nop(); step("redir_cnt", 1, 2'b00, 0, 0, O_NO, O_NO, 6, 1, 2, 2);
        nop(); step("mw1", 1, 2'b10, 1, 0, O_MEM, O_MEM, 6, 1, 2, 2);
        nop(); step("mw2", 1, 2'b10, 1, 0, O_MEM, O_MEM, 7, 1, 3, 2);
        nop(); step("mw3", 1, 2'b10, 1, 0, O_MEM, O_MEM, 8, 1, 4, 2);
        nop(); step("mw4", 1, 2'b10, 1, 0, O_MEM, O_MEM, 9, 1, 5, 2);
        nop(); step("mw_rdy", 1, 2'b10, 1, 1, O_RD, O_RD, 10, 1, 6, 2);
        nop(); step("mw_cnt", 1, 2'b00, 0, 0, O_NO, O_NO, 10, 2, 6, 3);
        nop(); step("redir2", 1, 2'b01, 0, 0, O_RD, O_RD, 10, 2, 6, 3);
        nop(); step("flush_sat", 1, 2'b00, 0, 0, O_NO, O_NO, 10, 3, 6, 4);
        hzd(); step("mem_vs_lu", 1, 2'b00, 1, 0, O_MEM, O_MEM, 10, 3, 6, 4);
        hzd(); step("lu_after", 1, 2'b00, 1, 1, O_LU, O_LU, 11, 3, 7, 4);
        nop(); step("frz_lu", 1, 2'b00, 1, 0, O_MEM, O_MEM, 12, 3, 8, 4);
        nop(); step("lu_resume", 1, 2'b00, 0, 0, O_LU, O_NO, 13, 3, 9, 4);
        nop(); step("lu_resume2", 1, 2'b00, 0, 0, O_LU, O_NO, 14, 3, 9, 4);
        nop(); step("lu_done", 1, 2'b00, 0, 0, O_NO, O_NO, 15, 3, 9, 4);
        hzd(); step("lu_pre_rst", 1, 2'b00, 0, 0, O_LU, O_LU, 15, 3, 9, 4);
        nop(); step("rst_lu", 0, 2'b00, 0, 0, O_NO, O_NO, 16, 3, 10, 4);
        nop(); step("post_rst_lu", 1, 2'b00, 0, 0, O_NO, O_NO, 0, 0, 0, 0);
        nop(); step("mem_pre_rst", 1, 2'b00, 1, 0, O_MEM, O_MEM, 0, 0, 0, 0);
        nop(); step("rst_mem", 0, 2'b00, 1, 0, O_NO, O_NO, 1, 0, 1, 0);
        nop(); step("post_rst_mem", 1, 2'b00, 0, 0, O_NO, O_NO, 0, 0, 0, 0);
        hzd(); step("lu_vs_rd", 1, 2'b01, 0, 0, O_LU, O_LU, 0, 0, 0, 0);
        nop(); step("lu_vs_rd2", 1, 2'b00, 0, 0, O_LU, O_NO, 1, 0, 1, 0);
        nop(); step("lu_vs_rd3", 1, 2'b00, 0, 0, O_LU, O_NO, 2, 0, 1, 0);
        nop(); step("lu_vs_rd4", 1, 2'b00, 0, 0, O_NO, O_NO, 3, 0, 1, 0);
        regs(1, 2'b01, 5'd5, 5'd4, 1, 5'd6, 1);
        step("no_match", 1, 2'b00, 0, 0, O_NO, O_NO, 3, 0, 1, 0);
        nop(); step("final", 1, 2'b00, 0, 0, O_NO, O_NO, 3, 0, 1, 0);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
